// File: rtl/cplx_buf_pkg.sv
// Shared types and helpers for the complex ping-pong frame buffer.
// Holds the default frame geometry, the complex word type and the bit-reversal helper.
package cplx_buf_pkg;

    localparam int CPLX_DEF_N      = 64;
    localparam int CPLX_DEF_W      = 32;
    localparam int CPLX_ADDR_MAX_W = 10;

    typedef struct packed {
        logic signed [CPLX_DEF_W-1:0] re;
        logic signed [CPLX_DEF_W-1:0] im;
    } cplx_t;

    // Reverses the low 'bits' bits of v; upper bits of v are expected to be zero.
    function automatic logic [CPLX_ADDR_MAX_W-1:0] bitrev(
        input logic [CPLX_ADDR_MAX_W-1:0] v,
        input int                         bits
    );
        logic [CPLX_ADDR_MAX_W-1:0] r;
        r = {<<{v}};
        return r >> (CPLX_ADDR_MAX_W - bits);
    endfunction

endpackage

// File: rtl/cplx_pingpong_buf_if.sv
// Serial-in / parallel-frame-out bus of the complex ping-pong buffer.
// The slave modport is the buffer side, the master modport is the producer/consumer side.
interface cplx_pingpong_buf_if
    import cplx_buf_pkg::*;
#(
    parameter int N = CPLX_DEF_N,
    parameter int W = CPLX_DEF_W
);

    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] in_re;
    logic signed [W-1:0] in_im;

    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] out_re [N];
    logic signed [W-1:0] out_im [N];

    logic [$clog2(N):0]  fill_cnt;

    modport slave (
        input  in_valid, in_re, in_im, out_ready,
        output in_ready, out_valid, out_re, out_im, fill_cnt
    );

    modport master (
        output in_valid, in_re, in_im, out_ready,
        input  in_ready, out_valid, out_re, out_im, fill_cnt
    );

endinterface

// File: rtl/cplx_pingpong_buf_bank.sv
// One frame bank of the ping-pong buffer: N complex words, single write port,
// whole-frame parallel read-out. Contents are zeroed on reset only.
module cplx_bank
    import cplx_buf_pkg::*;
#(
    parameter int N = CPLX_DEF_N,
    parameter int W = CPLX_DEF_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [$clog2(N)-1:0]   wr_addr,
    input  logic [2*W-1:0]         wr_data,
    output logic signed [W-1:0]    rd_re [N],
    output logic signed [W-1:0]    rd_im [N]
);

    logic signed [W-1:0] r_re [N];
    logic signed [W-1:0] r_im [N];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                r_re[i] <= '0;
                r_im[i] <= '0;
            end
        end else if (wr_en) begin
            r_re[wr_addr] <= wr_data[2*W-1:W];
            r_im[wr_addr] <= wr_data[W-1:0];
        end
    end

    assign rd_re = r_re;
    assign rd_im = r_im;

endmodule

// File: rtl/cplx_pingpong_buf.sv
// Complex ping-pong buffer: collects N serial samples into one bank while the other
// bank's frame is presented in parallel. Define CPLX_BUF_BITREV_EN for bit-reversed write order.
module cplx_pingpong_buf
    import cplx_buf_pkg::*;
#(
    parameter int N = CPLX_DEF_N,
    parameter int W = CPLX_DEF_W
) (
    input  logic                 clk,
    input  logic                 reset,
    cplx_pingpong_buf_if.slave   bus
);

    localparam int             AW   = $clog2(N);
    localparam logic [AW-1:0]  LAST = AW'(N - 1);

    logic            r_wb;
    logic            r_rb;
    logic [1:0]      r_full;
    logic [AW-1:0]   r_idx;

    logic            w_acc;
    logic            w_cons;
    logic [AW-1:0]   w_addr;
    logic [1:0]      w_wr_en;
    logic [2*W-1:0]  w_wr_data;

    logic signed [W-1:0] w_re0 [N];
    logic signed [W-1:0] w_im0 [N];
    logic signed [W-1:0] w_re1 [N];
    logic signed [W-1:0] w_im1 [N];

`ifdef CPLX_BUF_BITREV_EN
    logic [CPLX_ADDR_MAX_W-1:0] w_rev;
    assign w_rev  = bitrev(CPLX_ADDR_MAX_W'(r_idx), AW);
    assign w_addr = w_rev[AW-1:0];
`else
    assign w_addr = r_idx;
`endif

    // Handshake flags come straight from the bank flags, never from inputs.
    assign bus.in_ready  = !r_full[r_wb];
    assign bus.out_valid = r_full[r_rb];
    assign bus.fill_cnt  = {1'b0, r_idx};

    assign w_acc      = bus.in_valid  && !r_full[r_wb];
    assign w_cons     = bus.out_ready &&  r_full[r_rb];
    assign w_wr_en[0] = w_acc && !r_wb;
    assign w_wr_en[1] = w_acc &&  r_wb;
    assign w_wr_data  = {bus.in_re, bus.in_im};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wb   <= 1'b0;
            r_rb   <= 1'b0;
            r_full <= '0;
            r_idx  <= '0;
        end else begin
            if (w_acc) begin
                if (r_idx == LAST) begin
                    r_full[r_wb] <= 1'b1;
                    r_wb         <= ~r_wb;
                    r_idx        <= '0;
                end else begin
                    r_idx <= r_idx + AW'(1);
                end
            end
            // A fill and a consume in one cycle always hit different banks.
            if (w_cons) begin
                r_full[r_rb] <= 1'b0;
                r_rb         <= ~r_rb;
            end
        end
    end

    cplx_bank #(.N(N), .W(W)) u_bank0 (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (w_wr_en[0]),
        .wr_addr (w_addr),
        .wr_data (w_wr_data),
        .rd_re   (w_re0),
        .rd_im   (w_im0)
    );

    cplx_bank #(.N(N), .W(W)) u_bank1 (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (w_wr_en[1]),
        .wr_addr (w_addr),
        .wr_data (w_wr_data),
        .rd_re   (w_re1),
        .rd_im   (w_im1)
    );

    always_comb begin
        for (int i = 0; i < N; i++) begin
            bus.out_re[i] = r_rb ? w_re1[i] : w_re0[i];
            bus.out_im[i] = r_rb ? w_im1[i] : w_im0[i];
        end
    end

    // One full bank means the pointers differ; zero or two full banks means they agree.
    a_ptr_parity: assert property (@(posedge clk) disable iff (reset)
        (^r_full) == (r_wb ^ r_rb));

    a_split_banks: assert property (@(posedge clk) disable iff (reset)
        !(w_acc && w_cons) || (r_wb != r_rb));

endmodule

// File: tb/tb_cplx_pingpong_buf.sv
// Randomized bench for cplx_pingpong_buf (N=8, W=16) against a queue-based frame model.
module tb_cplx_pingpong_buf;

    localparam int N = 8;
    localparam int W = 16;

    logic clk = 1'b0;
    logic reset;

    cplx_pingpong_buf_if #(.N(N), .W(W)) bus ();

    cplx_pingpong_buf #(.N(N), .W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial forever #5 clk = ~clk;

    int n_chk   = 0;
    int n_fail  = 0;
    int n_deliv = 0;
    int n_busy  = 0;
    bit chk_en  = 0;
    bit cont_ph = 0;

    // Model: samples of the partial frame, then complete frames oldest-first, flattened.
    logic [2*W-1:0] cq[$];
    logic [2*W-1:0] fq[$];

    function automatic int addr(input int k);
`ifdef CPLX_BUF_BITREV_EN
        int t[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
        return t[k];
`else
        return k;
`endif
    endfunction

    function automatic logic [31:0] u(input logic [W-1:0] x);
        return {16'b0, x};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input string nm);
        logic [31:0] acc;
        acc = '0;
        for (int k = 0; k < N; k++) acc = acc | u(bus.out_re[k]) | u(bus.out_im[k]);
        chk(nm, acc, 32'd0);
    endtask

    task automatic step(input bit rst, input bit v, input logic [W-1:0] re,
                        input logic [W-1:0] im, input bit ordy);
        reset         = rst;
        bus.in_valid  = v;
        bus.in_re     = re;
        bus.in_im     = im;
        bus.out_ready = ordy;
        @(negedge clk);
    endtask

    always @(posedge clk) begin : model
        int nfr;
        nfr = fq.size() / N;
        if (reset) begin
            cq.delete();
            fq.delete();
        end else begin
            if (bus.out_ready && nfr > 0) begin
                for (int i = 0; i < N; i++) void'(fq.pop_front());
                n_deliv++;
            end
            if (bus.in_valid && nfr < 2) begin
                cq.push_back({bus.in_re, bus.in_im});
                if (cq.size() == N) begin
                    for (int i = 0; i < N; i++) fq.push_back(cq[i]);
                    cq.delete();
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        int nfr;
        if (chk_en) begin
            nfr = fq.size() / N;
            chk("in_ready", 32'(bus.in_ready), 32'(nfr < 2));
            chk("out_valid", 32'(bus.out_valid), 32'(nfr > 0));
            chk("fill_cnt", 32'(bus.fill_cnt), 32'(cq.size()));
            if (nfr > 0) begin
                for (int k = 0; k < N; k++) begin
                    chk("frame_re", u(bus.out_re[addr(k)]), u(fq[k][2*W-1:W]));
                    chk("frame_im", u(bus.out_im[addr(k)]), u(fq[k][W-1:0]));
                end
            end
            if (cont_ph && !bus.in_ready) n_busy++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual running required finished");
        $fatal(1);
    end

    initial begin : stim
        int d0;
        chk_en = 1;
        step(1, 0, '0, '0, 0);
        step(1, 0, '0, '0, 0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_fill_cnt", 32'(bus.fill_cnt), 32'd0);
        chk_zero("rst_out_zero");

        // First frame: re=k, im=-k, consumer stalled.
        for (int k = 0; k < N; k++) begin
            step(0, 1, 16'(k), 16'(-k), 0);
            if (k == N - 2) chk("valid_before_last", 32'(bus.out_valid), 32'd0);
        end
        chk("valid_after_last", 32'(bus.out_valid), 32'd1);
        for (int k = 0; k < N; k++) begin
            chk("frameA_re", u(bus.out_re[addr(k)]), u(16'(k)));
            chk("frameA_im", u(bus.out_im[addr(k)]), u(16'(-k)));
        end

        // Second frame fills bank 1, then both banks are full.
        for (int k = 0; k < N; k++) step(0, 1, 16'(100 + k), 16'($urandom), 0);
        chk("both_full_in_ready", 32'(bus.in_ready), 32'd0);
        for (int k = 0; k < 3; k++) step(0, 1, 16'($urandom), 16'($urandom), 0);
        chk("held_frameA", u(bus.out_re[addr(3)]), u(16'd3));
        chk("held_fill_cnt", 32'(bus.fill_cnt), 32'd0);

        // One-cycle consume pulse.
        step(0, 0, '0, '0, 1);
        chk("frameB_valid", 32'(bus.out_valid), 32'd1);
        chk("frameB_in_ready", 32'(bus.in_ready), 32'd1);
        chk("frameB_fill_cnt", 32'(bus.fill_cnt), 32'd0);
        chk("frameB_re0", u(bus.out_re[addr(0)]), u(16'd100));
        step(0, 0, '0, '0, 1);
        chk("drained_valid", 32'(bus.out_valid), 32'd0);

        // Random traffic: heavy backpressure, then a light one, with rare resets.
        for (int c = 0; c < 400; c++)
            step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                 16'($urandom), 16'($urandom),
                 (c < 200) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 3) != 0));

        // Streaming at full rate.
        step(1, 0, '0, '0, 0);
        d0 = n_deliv;
        cont_ph = 1;
        for (int c = 0; c < 64; c++) step(0, 1, 16'($urandom), 16'($urandom), 1);
        step(0, 0, '0, '0, 1);
        cont_ph = 0;
        chk("stream_frames", 32'(n_deliv - d0), 32'd8);
        chk("stream_ready_drops", 32'(n_busy), 32'd0);

        // Reset in the middle of a fill, with reset overriding valid/ready.
        step(1, 0, '0, '0, 0);
        for (int k = 0; k < 5; k++) step(0, 1, 16'($urandom), 16'($urandom), 0);
        step(1, 1, 16'($urandom), 16'($urandom), 1);
        chk("midrst_fill_cnt", 32'(bus.fill_cnt), 32'd0);
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        chk_zero("midrst_out_zero");
        for (int k = 0; k < N; k++) step(0, 1, 16'(50 + k), 16'(~k), 0);
        chk("postrst_valid", 32'(bus.out_valid), 32'd1);
        chk("postrst_re7", u(bus.out_re[addr(7)]), u(16'd57));
        chk("postrst_im2", u(bus.out_im[addr(2)]), u(16'hfffd));
        step(0, 0, '0, '0, 1);
        step(0, 0, '0, '0, 0);

        chk_en = 0;
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
